// File: rtl/seq_pkg.sv
// Shared encodings and constants for the zero-run sync link (transmitter and detector).
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_STUFF,
    ST_STOP
  } state_e;

  localparam logic SYNC_VAL     = 1'b0;
  localparam logic MARK         = 1'b1;
  localparam int   DEF_SYNC_LEN = 3;

endpackage

// File: rtl/seq_bit_tick.sv
// Bit-period divider: a one-cycle tick every CLK_DIV cycles, realigned by restart_i.
module seq_bit_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart loads a full period so the first bit after acceptance lasts CLK_DIV cycles.
  always_comb begin
    tick_o = (cnt_q == '0);
    cnt_d  = cnt_q - 1'b1;
    if (restart_i || tick_o) cnt_d = RELOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_frame_tx.sv
// Zero-run sync framing transmitter: sync zeros, start bit, zero-stuffed MSB-first payload, stop bit.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int CLK_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int RW = $clog2(SYNC_LEN + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [RW-1:0] RUN_LIM  = RW'(SYNC_LEN - 1);
  localparam logic [BW-1:0] NBITS    = BW'(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [RW-1:0]     sync_q, sync_d;
  logic [RW-1:0]     run_q, run_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic              dout_q, dout_d;
  logic              done_q, done_d;
  logic              restart, tick;

  seq_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    sync_d  = sync_q;
    run_d   = run_q;
    bits_d  = bits_q;
    done_d  = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: if (valid) begin
        sr_d    = data_in;
        sync_d  = '0;
        restart = 1'b1;
        state_d = ST_SYNC;
      end
      ST_SYNC: if (tick) begin
        if (sync_q == RUN_LIM) state_d = ST_START;
        else                   sync_d  = sync_q + 1'b1;
      end
      ST_START: if (tick) begin
        run_d   = '0;
        bits_d  = NBITS;
        state_d = ST_DATA;
      end
      ST_DATA: if (tick) begin
        sr_d   = sr_q << 1;
        bits_d = bits_q - 1'b1;
        run_d  = sr_q[DATA_W-1] ? '0 : run_q + 1'b1;
        // The final payload bit is never stuffed: the stop bit breaks the run.
        if (bits_q == LAST_BIT)     state_d = ST_STOP;
        else if (run_d == RUN_LIM)  state_d = ST_STUFF;
      end
      ST_STUFF: if (tick) begin
        run_d   = '0;
        state_d = ST_DATA;
      end
      ST_STOP: if (tick) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // dout is registered alongside state, so it is derived from the next state.
    unique case (state_d)
      ST_SYNC: dout_d = SYNC_VAL;
      ST_DATA: dout_d = sr_d[DATA_W-1];
      default: dout_d = MARK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      sync_q  <= '0;
      run_q   <= '0;
      bits_q  <= '0;
      dout_q  <= MARK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sync_q  <= sync_d;
      run_q   <= run_d;
      bits_q  <= bits_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dout_en    = (state_q != ST_IDLE);
  assign dout       = dout_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: directed frames plus random words against a queue-based frame model.
module tb_seq_frame_tx;

  localparam int DW = 8;
  localparam int SL = 3;

  typedef logic bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b, valid_a, valid_b;
  logic [DW-1:0] din_a, din_b;
  logic ready_a, dout_a, en_a, busy_a, done_a;
  logic ready_b, dout_b, en_b, busy_b, done_b;

  seq_frame_tx #(.DATA_W(DW), .SYNC_LEN(SL), .CLK_DIV(1)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(din_a), .valid(valid_a), .ready(ready_a),
    .dout(dout_a), .dout_en(en_a), .busy(busy_a), .frame_done(done_a));

  seq_frame_tx #(.DATA_W(DW), .SYNC_LEN(SL), .CLK_DIV(4)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(din_b), .valid(valid_b), .ready(ready_b),
    .dout(dout_b), .dout_en(en_b), .busy(busy_b), .frame_done(done_b));

  logic sel = 1'b0;
  wire s_dout  = sel ? dout_b  : dout_a;
  wire s_en    = sel ? en_b    : en_a;
  wire s_busy  = sel ? busy_b  : busy_a;
  wire s_done  = sel ? done_b  : done_a;
  wire s_ready = sel ? ready_b : ready_a;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of bits: sync zeros, start, payload with a stuffed 1 after
  // every SL-1 zero run that is not at the end, stop.
  function automatic bq_t frame_bits(input logic [DW-1:0] w);
    bq_t q;
    int run = 0;
    for (int i = 0; i < SL; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = DW-1; i >= 0; i--) begin
      q.push_back(w[i]);
      run = w[i] ? 0 : run + 1;
      if (run == SL-1 && i > 0) begin
        q.push_back(1'b1);
        run = 0;
      end
    end
    q.push_back(1'b1);
    return q;
  endfunction

  // Non-overlapping zero-run detector fed with idle 1 followed by the frame bits.
  function automatic int det_fires(input bq_t bits);
    int run = 0;
    int fires = 0;
    foreach (bits[i]) begin
      if (bits[i] === 1'b0) begin
        run++;
        if (run == SL) begin fires++; run = 0; end
      end else run = 0;
    end
    return fires;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d);
    if (sel) begin valid_b = v; din_b = d; end
    else     begin valid_a = v; din_a = d; end
  endtask

  // Called just before the accepting edge; returns at the frame_done cycle
  // (or one cycle later when the next word is not pending).
  task automatic check_frame(input logic [DW-1:0] w, input int div, input int exp_len,
                             input bit hold, input logic [DW-1:0] nxt);
    bq_t exp = frame_bits(w);
    bq_t obs;
    bq_t per_bit;
    int spurious = 0;
    int held_bad = 0;
    per_bit.push_back(1'b1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (s_en !== 1'b1) break;
      obs.push_back(s_dout);
      if (s_done !== 1'b0 || s_ready !== 1'b0 || s_busy !== 1'b1) spurious++;
      drive(hold, DW'($urandom));
    end
    drive(hold, nxt);
    chk($sformatf("len_cycles_%02h", w), obs.size(), exp.size() * div);
    if (exp_len > 0) chk($sformatf("len_bits_%02h", w), obs.size() / div, exp_len);
    chk($sformatf("flags_in_frame_%02h", w), spurious, 0);
    foreach (exp[k]) begin
      logic [1:0] ov;
      ov = (k*div < obs.size()) ? {1'b0, obs[k*div]} : 2'd2;
      for (int j = 1; j < div; j++)
        if (k*div+j >= obs.size() || obs[k*div+j] !== obs[k*div]) held_bad++;
      chk($sformatf("bit%0d_%02h", k, w), ov, {1'b0, exp[k]});
      per_bit.push_back(ov[0]);
    end
    if (div > 1) chk($sformatf("bit_hold_%02h", w), held_bad, 0);
    chk($sformatf("det_fires_%02h", w), det_fires(per_bit), 1);
    chk($sformatf("done_pulse_%02h", w), s_done, 1'b1);
    chk($sformatf("ready_after_%02h", w), s_ready, 1'b1);
    chk($sformatf("idle_dout_%02h", w), {s_dout, s_en, s_busy}, 3'b100);
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("done_one_cycle_%02h", w), {s_done, s_ready}, 2'b01);
    end
  endtask

  task automatic send(input logic [DW-1:0] w, input int div, input int exp_len,
                      input bit hold, input logic [DW-1:0] nxt);
    @(negedge clk);
    drive(1'b1, w);
    check_frame(w, div, exp_len, hold, nxt);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    din_a = '0; din_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_b", {dout_b, en_b, busy_b, done_b}, 4'b1000);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_%0d", i), {dout_a, ready_a, en_a, busy_a, done_a}, 5'b11000);
    end

    sel = 1'b0;
    send(8'hFF, 1, 13, 1'b0, 8'h00);
    send(8'h00, 1, 16, 1'b0, 8'h00);
    send(8'hA4, 1, 14, 1'b0, 8'h00);
    send(8'h3C, 1, 0, 1'b1, 8'hC3);
    check_frame(8'hC3, 1, 0, 1'b0, 8'h00);

    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] w;
      int gap;
      w = DW'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_ready", {ready_a, en_a}, 2'b10);
      end
      send(w, 1, 0, 1'b0, 8'h00);
    end

    sel = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'h5A);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      drive(1'b0, 8'h00);
    end
    chk("abort_in_frame", {en_b, busy_b}, 2'b11);
    rst_b = 1'b0;
    @(negedge clk);
    chk("abort_state", {dout_b, en_b, busy_b, done_b}, 4'b1000);
    rst_b = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_done", {done_b, ready_b, en_b}, 3'b010);
    end
    send(8'hA4, 4, 14, 1'b0, 8'h00);
    send(8'h00, 4, 16, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
